// File: rtl/map_fill_writer.sv
// map_fill_writer: fills a rectangular region of the 70x50 map RAM with a constant
// value, one RAM write per clock, at address row*MAP_W + col (row-major scan).
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   cmd_valid  fill command present
//   cmd_ready  command can be accepted this cycle (IDLE and no clear request)
//   cmd_x0     left column of the rectangle
//   cmd_y0     top row of the rectangle
//   cmd_w      width in cells
//   cmd_h      height in cells
//   cmd_data   fill value
//   clear      request a fill of the whole map with 0 (wins over cmd_valid)
//   we         map RAM write enable
//   waddr      map RAM write address
//   wdata      map RAM write data (holds its last value between writes)
//   busy       a fill is in progress (SETUP, FILL, DONE)
//   done       one-cycle pulse when a command completes
module map_fill_writer #(
    parameter int unsigned MAP_W  = 70,
    parameter int unsigned MAP_H  = 50,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [6:0]        cmd_x0,
    input  logic [5:0]        cmd_y0,
    input  logic [6:0]        cmd_w,
    input  logic [5:0]        cmd_h,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              clear,
    output logic              we,
    output logic [11:0]       waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0]  MapW8   = 8'(MAP_W);
    localparam logic [7:0]  MapH8   = 8'(MAP_H);
    localparam logic [11:0] MapW12  = 12'(MAP_W);

    typedef enum logic [1:0] {StIdle, StSetup, StFill, StDone} state_e;

    state_e              state_q, state_d;
    logic [6:0]          x0_q, x0_d;
    logic [5:0]          y0_q, y0_d;
    logic [6:0]          w_q, w_d;
    logic [5:0]          h_q, h_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [6:0]          x_end_q, x_end_d;
    logic [5:0]          y_end_q, y_end_d;
    logic [6:0]          col_q, col_d;
    logic [5:0]          row_q, row_d;
    logic [11:0]         row_base_q, row_base_d;
    logic                we_q, we_d;
    logic [11:0]         waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Clipping arithmetic on the latched command (only meaningful in SETUP).
    logic [7:0]  x_sum, y_sum;
    logic [6:0]  x_end_c;
    logic [5:0]  y_end_c;
    logic        empty_c;
    logic [11:0] y0_ext, base_c, next_base;
    logic        last_col, last_row;

    assign x_sum   = {1'b0, x0_q} + {1'b0, w_q};
    assign y_sum   = {2'b0, y0_q} + {2'b0, h_q};
    assign x_end_c = (x_sum > MapW8) ? MapW8[6:0] : x_sum[6:0];
    assign y_end_c = (y_sum > MapH8) ? MapH8[5:0] : y_sum[5:0];
    assign empty_c = ({1'b0, x0_q} >= MapW8) || ({2'b0, y0_q} >= MapH8) ||
                     (w_q == 7'd0) || (h_q == 6'd0);

    // y0*70 as 64+4+2; only evaluated for y0 < MAP_H so it never overflows.
    assign y0_ext    = {6'b0, y0_q};
    assign base_c    = (y0_ext << 6) + (y0_ext << 2) + (y0_ext << 1);
    assign next_base = row_base_q + MapW12;
    assign last_col  = (col_q == x_end_q - 7'd1);
    assign last_row  = (row_q == y_end_q - 6'd1);

    assign cmd_ready = (state_q == StIdle) && !clear;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        data_d     = data_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (clear) begin
                    x0_d    = 7'd0;
                    y0_d    = 6'd0;
                    w_d     = 7'(MAP_W);
                    h_d     = 6'(MAP_H);
                    data_d  = '0;
                    state_d = StSetup;
                    busy_d  = 1'b1;
                end else if (cmd_valid) begin
                    x0_d    = cmd_x0;
                    y0_d    = cmd_y0;
                    w_d     = cmd_w;
                    h_d     = cmd_h;
                    data_d  = cmd_data;
                    state_d = StSetup;
                    busy_d  = 1'b1;
                end
            end
            StSetup: begin
                x_end_d = x_end_c;
                y_end_d = y_end_c;
                if (empty_c) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    // Issue the first write straight out of SETUP.
                    state_d    = StFill;
                    col_d      = x0_q;
                    row_d      = y0_q;
                    row_base_d = base_c;
                    we_d       = 1'b1;
                    waddr_d    = base_c + {5'b0, x0_q};
                    wdata_d    = data_q;
                end
            end
            StFill: begin
                // Outputs currently show the write for (row_q, col_q); schedule the next.
                if (last_col && last_row) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if (last_col) begin
                    col_d      = x0_q;
                    row_d      = row_q + 6'd1;
                    row_base_d = next_base;
                    we_d       = 1'b1;
                    waddr_d    = next_base + {5'b0, x0_q};
                end else begin
                    col_d   = col_q + 7'd1;
                    we_d    = 1'b1;
                    waddr_d = row_base_q + {5'b0, col_q + 7'd1};
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            data_q     <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            data_q     <= data_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_map_fill_writer.sv
// Self-checking bench for map_fill_writer: directed cases plus randomized commands,
// each compared cycle by cycle against a rectangle-scan reference model.
module tb_map_fill_writer;

    localparam int MAP_W  = 70;
    localparam int MAP_H  = 50;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [6:0]        cmd_x0;
    logic [5:0]        cmd_y0;
    logic [6:0]        cmd_w;
    logic [5:0]        cmd_h;
    logic [DATA_W-1:0] cmd_data;
    logic              clear;
    logic              we;
    logic [11:0]       waddr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    map_fill_writer #(
        .MAP_W (MAP_W),
        .MAP_H (MAP_H),
        .DATA_W(DATA_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_x0   (cmd_x0),
        .cmd_y0   (cmd_y0),
        .cmd_w    (cmd_w),
        .cmd_h    (cmd_h),
        .cmd_data (cmd_data),
        .clear    (clear),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected write addresses for a rectangle, straight from the clipping rules.
    task automatic model_addrs(input int x0, input int y0, input int w, input int h,
                               output int q[$]);
        int xe, ye;
        q = {};
        xe = (x0 + w < MAP_W) ? x0 + w : MAP_W;
        ye = (y0 + h < MAP_H) ? y0 + h : MAP_H;
        if (x0 < MAP_W && y0 < MAP_H && w > 0 && h > 0)
            for (int r = y0; r < ye; r++)
                for (int c = x0; c < xe; c++)
                    q.push_back(r * MAP_W + c);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle.
    task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                           input logic [7:0] data, input bit use_clear, input bit hold_valid);
        int q[$];
        logic [7:0] d;
        if (use_clear) model_addrs(0, 0, MAP_W, MAP_H, q);
        else           model_addrs(x0, y0, w, h, q);
        d = use_clear ? 8'd0 : data;

        cmd_x0    = 7'(x0);
        cmd_y0    = 6'(y0);
        cmd_w     = 7'(w);
        cmd_h     = 6'(h);
        cmd_data  = data;
        cmd_valid = 1'b1;
        clear     = use_clear;
        #1;
        check_eq("ready_at_accept", cmd_ready, use_clear ? 1'b0 : 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_eq("setup_busy", busy, 1);
        check_eq("setup_we", we, 0);
        check_eq("setup_done", done, 0);
        check_eq("setup_ready", cmd_ready, 0);
        clear     = 1'b0;
        cmd_valid = hold_valid;
        cmd_x0    = 7'($urandom);
        cmd_y0    = 6'($urandom);
        cmd_w     = 7'($urandom);
        cmd_h     = 6'($urandom);
        cmd_data  = 8'($urandom);
        foreach (q[i]) begin
            @(negedge clk);
            check_eq("fill_we", we, 1);
            check_eq("fill_waddr", waddr, q[i]);
            check_eq("fill_wdata", wdata, d);
            check_eq("fill_busy", busy, 1);
            check_eq("fill_done", done, 0);
        end
        @(negedge clk);
        check_eq("done_pulse", done, 1);
        check_eq("done_we", we, 0);
        check_eq("done_busy", busy, 1);
        @(negedge clk);
        check_eq("idle_done", done, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_we", we, 0);
        check_eq("idle_ready", cmd_ready, 1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int x0, y0, w, h;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        clear     = 1'b0;
        cmd_x0    = '0;
        cmd_y0    = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_data  = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_we", we, 0);
        check_eq("rst_waddr", waddr, 0);
        check_eq("rst_wdata", wdata, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        reset = 1'b0;
        #1;
        check_eq("rst_ready", cmd_ready, 1);
        @(negedge clk);

        // Directed cases.
        run_cmd(0, 0, 1, 1, 8'h05, 0, 0);
        run_cmd(68, 48, 3, 2, 8'h0A, 0, 0);
        run_cmd(10, 3, 3, 2, 8'h3C, 0, 1);
        run_cmd(5, 5, 0, 3, 8'h11, 0, 0);
        run_cmd(80, 5, 3, 3, 8'h22, 0, 0);
        run_cmd(5, 50, 3, 3, 8'h33, 0, 0);
        run_cmd(127, 63, 127, 63, 8'h44, 0, 0);
        run_cmd(0, 0, 0, 0, 8'h77, 1, 1);       // full clear with cmd_valid also high

        // Reset during the third write of a 5x5 fill at (2,2).
        cmd_x0 = 7'd2; cmd_y0 = 6'd2; cmd_w = 7'd5; cmd_h = 6'd5; cmd_data = 8'h99;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_we", we, 1);
        check_eq("pre_rst_waddr", waddr, 2 * MAP_W + 4);
        reset = 1'b1;
        #1;
        check_eq("async_rst_we", we, 0);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_done", done, 0);
        check_eq("async_rst_waddr", waddr, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check_eq("post_rst_we", we, 0);
            check_eq("post_rst_busy", busy, 0);
            check_eq("post_rst_ready", cmd_ready, 1);
        end

        // Randomized commands, biased toward the clipping edges.
        for (int k = 0; k < 40; k++) begin
            x0 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 69);
            y0 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 63)  : $urandom_range(0, 49);
            w  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 12);
            h  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63)  : $urandom_range(0, 6);
            run_cmd(x0, y0, w, h, 8'($urandom), 0, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
